goldschmidt_div_seq: RTL and testbench

//  Iterative Goldschmidt mantissa divider, parametrised in width and iteration count.

---
 rtl/goldschmidt_div_seq_pkg.sv | 12 +
 rtl/goldschmidt_div_seq_if.sv | 8 +
 rtl/goldschmidt_div_seq_mul_trunc.sv | 10 +
 rtl/goldschmidt_div_seq.sv | 59 +++++
 tb/tb_goldschmidt_div_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/goldschmidt_div_seq_pkg.sv
// goldschmidt_div_seq_pkg: shared FSM state type and fixed-point helpers for the Goldschmidt divider
package goldschmidt_div_seq_pkg;
  typedef enum logic [1:0] {IDLE, MUL_N, MUL_D, DONE} gs_state_t;
  localparam int MAX_W = 64;
  function automatic int fix_one(input int w);
    return 1 << (w - 2);
  endfunction
  // A U2.(w-2) x U2.(w-2) product is U4.(2w-4); keep bits [2w-3 : w-2], i.e. drop two integer MSBs and chop the LSBs.
  function automatic logic [MAX_W-1:0] trunc_prod(input logic [2*MAX_W-1:0] p, input int w);
    return MAX_W'(p >> (w - 2)) & ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction
endpackage

// File: rtl/goldschmidt_div_seq_if.sv
// goldschmidt_div_seq_if: operand/quotient handshake bundle for the Goldschmidt divider
interface goldschmidt_div_seq_if #(parameter int WIDTH = 27, parameter int Q_W = 24);
  logic in_valid, in_ready, out_valid, out_ready, lt_one, busy;
  logic [WIDTH-1:0] num, denom;
  logic [Q_W-1:0] quot;
  modport master(output in_valid, num, denom, out_ready, input in_ready, out_valid, quot, lt_one, busy);
  modport slave(input in_valid, num, denom, out_ready, output in_ready, out_valid, quot, lt_one, busy);
endinterface

// File: rtl/goldschmidt_div_seq_mul_trunc.sv
// gs_mul_trunc: combinational fixed-point multiply returning the U2.(WIDTH-2) window of the product
module gs_mul_trunc import goldschmidt_div_seq_pkg::*; #(parameter int WIDTH = 27) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [2*WIDTH-1:0] p;
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign y = WIDTH'(trunc_prod((2*MAX_W)'(p), WIDTH));
endmodule

// File: rtl/goldschmidt_div_seq.sv
// goldschmidt_div_seq: iterative Goldschmidt mantissa divider sharing one multiplier between N and D updates
module goldschmidt_div_seq import goldschmidt_div_seq_pkg::*; #(
  parameter int WIDTH = 27,
  parameter int Q_W = 24,
  parameter int ITERS = 5,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(3) << (WIDTH - 4)
) (
  input logic clk,
  input logic reset,
  goldschmidt_div_seq_if.slave bus
);
  localparam int CW = $clog2(ITERS + 1) + 1;
  gs_state_t state, state_nx;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] n_r, d_r, k_r, op, prod;
  logic accept;
  assign accept = state == IDLE && bus.in_valid;
  assign op = state == MUL_D ? d_r : n_r;
  gs_mul_trunc #(.WIDTH(WIDTH)) u_mul (.a(op), .b(k_r), .y(prod));
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.quot = n_r[WIDTH-1 -: Q_W];
  assign bus.lt_one = state == DONE && n_r[WIDTH-1:WIDTH-2] == 2'b00;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: seed pair plus ITERS refinement pairs, then hold result until consumed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.in_valid ? MUL_N : IDLE;
      MUL_N:   state_nx = MUL_D;
      MUL_D:   state_nx = count == CW'(ITERS) ? DONE : MUL_N;
      DONE:    state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // iterate registers: N and D both scaled by K; next K is the ones-complement of the new D (2-D-ulp)
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      n_r <= '0;
      d_r <= '0;
      k_r <= '0;
    end else if (accept) begin
      count <= '0;
      n_r <= bus.num;
      d_r <= bus.denom;
      k_r <= SEED;
    end else if (state == MUL_N) begin
      n_r <= prod;
    end else if (state == MUL_D) begin
      d_r <= prod;
      k_r <= {1'b0, ~prod[WIDTH-2:0]};
      count <= count + CW'(1);
    end
endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// tb_goldschmidt_div_seq: table, corner-sequence and random checks of the Goldschmidt divider
module tb_goldschmidt_div_seq;
  logic clk = 0;
  logic reset = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  goldschmidt_div_seq_if #(.WIDTH(27), .Q_W(24)) b5();
  goldschmidt_div_seq_if #(.WIDTH(27), .Q_W(24)) b3();
  goldschmidt_div_seq #(.WIDTH(27), .Q_W(24), .ITERS(5)) u5 (.clk(clk), .reset(reset), .bus(b5));
  goldschmidt_div_seq #(.WIDTH(27), .Q_W(24), .ITERS(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    logic [26:0] n;
    logic [26:0] d;
    logic [23:0] q;
    logic lt;
  } vec_t;

  // reference: Goldschmidt refinement in plain 64-bit integer arithmetic
  function automatic logic [26:0] gs_model(input logic [26:0] n, input logic [26:0] d, input int iters);
    logic [63:0] nn, dd, kk, mask;
    nn = 64'(n);
    dd = 64'(d);
    kk = 64'h3 << 23;
    mask = (64'h1 << 27) - 1;
    for (int i = 0; i <= iters; i++) begin
      nn = ((nn * kk) >> 25) & mask;
      dd = ((dd * kk) >> 25) & mask;
      kk = ~dd & ((64'h1 << 26) - 1);
    end
    return nn[26:0];
  endfunction

  task automatic chk(input string name, input logic ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int it, input logic v, input logic [26:0] n, input logic [26:0] d, input logic rdy);
    if (it == 5) begin
      b5.in_valid = v; b5.num = n; b5.denom = d; b5.out_ready = rdy;
    end else begin
      b3.in_valid = v; b3.num = n; b3.denom = d; b3.out_ready = rdy;
    end
  endtask

  function automatic logic ov(input int it);
    return it == 5 ? b5.out_valid : b3.out_valid;
  endfunction

  // one transaction: accept, wait (bounded) for out_valid, hold `hold` cycles, consume
  task automatic run_op(input int it, input logic [26:0] n, input logic [26:0] d, input int hold,
                        output logic [23:0] q, output logic lt, output int lat);
    drive(it, 1, n, d, 0);
    @(posedge clk); #1;
    drive(it, 0, n, d, 0);
    lat = 0;
    while (!ov(it) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    q = it == 5 ? b5.quot : b3.quot;
    lt = it == 5 ? b5.lt_one : b3.lt_one;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    drive(it, 0, n, d, 1);
    @(posedge clk); #1;
    drive(it, 0, n, d, 0);
  endtask

  task automatic check_op(input string name, input int it, input logic [26:0] n, input logic [26:0] d,
                          input logic [23:0] q, input logic lt, input int lat, input real tol);
    logic [26:0] m;
    real err;
    m = gs_model(n, d, it);
    err = real'(q) / 4194304.0 - real'(n) / real'(d);
    if (err < 0.0) err = -err;
    chk({name, "_quot"}, q == m[26:3], q, m[26:3]);
    chk({name, "_lt_one"}, lt == (m[26:25] == 2'b00), lt, m[26:25] == 2'b00);
    chk({name, "_latency"}, lat == 2 * (it + 1), lat, 2 * (it + 1));
    chk({name, "_accuracy"}, err <= tol, longint'(err * 33554432.0), longint'(tol * 33554432.0));
  endtask

  logic [26:0] rn, rd;

  function automatic logic [26:0] rnd_mant();
    return 27'h2000000 | 27'($urandom() & 32'h1FFFFFF);
  endfunction

  initial begin
    vec_t tv[6];
    logic [23:0] q, q0;
    logic lt;
    int lat, dq;
    logic [26:0] bn[4], bd[4];
    int acc_t[$];
    logic [23:0] got[$];
    int idx, cyc;
    logic acc;
    tv[0] = '{27'h3000000, 27'h2000000, 24'h600000, 1'b0};
    tv[1] = '{27'h2000000, 27'h3000000, 24'h2AAAAA, 1'b1};
    tv[2] = '{27'h3800000, 27'h2800000, 24'h599999, 1'b0};
    tv[3] = '{27'h2800000, 27'h3800000, 24'h2DB6DB, 1'b1};
    tv[4] = '{27'h3FFFFFF, 27'h2000000, 24'h7FFFFF, 1'b0};
    tv[5] = '{27'h2000000, 27'h3FFFFFF, 24'h200000, 1'b1};
    drive(5, 0, '0, '0, 0);
    drive(3, 0, '0, '0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", b5.in_ready == 1'b1, b5.in_ready, 1);
    chk("rst_out_valid", b5.out_valid == 1'b0, b5.out_valid, 0);
    chk("rst_quot", b5.quot == 24'h0, b5.quot, 0);
    chk("rst_lt_one", b5.lt_one == 1'b0, b5.lt_one, 0);
    chk("rst_busy", b5.busy == 1'b0, b5.busy, 0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    // directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(5, tv[i].n, tv[i].d, i % 3, q, lt, lat);
      dq = int'(q) - int'(tv[i].q);
      if (dq < 0) dq = -dq;
      chk($sformatf("vec%0d_near", i), dq <= 2, q, tv[i].q);
      chk($sformatf("vec%0d_lt_one", i), lt == tv[i].lt, lt, tv[i].lt);
      check_op($sformatf("vec%0d", i), 5, tv[i].n, tv[i].d, q, lt, lat, 2.0 ** -21);
    end
    // result held under backpressure; in_valid pulses during DONE are ignored
    drive(5, 1, 27'h3000000, 27'h2000000, 0);
    @(posedge clk); #1;
    drive(5, 0, 27'h3000000, 27'h2000000, 0);
    lat = 0;
    while (!b5.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    q0 = b5.quot;
    rn = gs_model(27'h3000000, 27'h2000000, 5);
    chk("hold_first", b5.out_valid && q0 == rn[26:3], q0, rn[26:3]);
    for (int i = 0; i < 5; i++) begin
      drive(5, i % 2 == 0, 27'h2800000, 27'h3800000, 0);
      @(posedge clk); #1;
      chk("hold_valid", b5.out_valid == 1'b1, b5.out_valid, 1);
      chk("hold_quot", b5.quot == q0, b5.quot, q0);
      chk("hold_in_ready", b5.in_ready == 1'b0, b5.in_ready, 0);
    end
    drive(5, 0, '0, '0, 1);
    @(posedge clk); #1;
    drive(5, 0, '0, '0, 0);
    chk("release_in_ready", b5.in_ready == 1'b1, b5.in_ready, 1);
    chk("release_out_valid", b5.out_valid == 1'b0, b5.out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_op", b5.busy == 1'b0, b5.busy, 0);
    // asynchronous reset during MUL_D of refinement iteration 3
    drive(5, 1, 27'h3000000, 27'h2800000, 0);
    @(posedge clk); #1;
    drive(5, 0, 27'h3000000, 27'h2800000, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy_before", b5.busy == 1'b1, b5.busy, 1);
    #1 reset = 0;
    #1;
    chk("mid_rst_out_valid", b5.out_valid == 1'b0, b5.out_valid, 0);
    chk("mid_rst_busy", b5.busy == 1'b0, b5.busy, 0);
    chk("mid_rst_in_ready", b5.in_ready == 1'b1, b5.in_ready, 1);
    chk("mid_rst_quot", b5.quot == 24'h0, b5.quot, 0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    run_op(5, 27'h2000000, 27'h3000000, 0, q, lt, lat);
    check_op("after_rst", 5, 27'h2000000, 27'h3000000, q, lt, lat, 2.0 ** -21);
    // back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) begin
      bn[i] = rnd_mant();
      bd[i] = rnd_mant();
    end
    idx = 0;
    cyc = 0;
    drive(5, 1, bn[0], bd[0], 1);
    while (got.size() < 4 && cyc < 200) begin
      @(negedge clk);
      acc = b5.in_ready && idx < 4;
      if (b5.out_valid) got.push_back(b5.quot);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_t.push_back(cyc);
        idx++;
        drive(5, idx < 4, bn[idx % 4], bd[idx % 4], 1);
      end
    end
    drive(5, 0, '0, '0, 0);
    chk("b2b_count", got.size() == 4, got.size(), 4);
    for (int i = 1; i < acc_t.size(); i++)
      chk("b2b_interval", acc_t[i] - acc_t[i-1] == 14, acc_t[i] - acc_t[i-1], 14);
    for (int i = 0; i < got.size(); i++) begin
      rn = gs_model(bn[i], bd[i], 5);
      chk("b2b_order", got[i] == rn[26:3], got[i], rn[26:3]);
    end
    repeat (2) @(posedge clk);
    #1;
    // random operands on both iteration counts
    for (int i = 0; i < 200; i++) begin
      rn = rnd_mant();
      rd = rnd_mant();
      run_op(5, rn, rd, $urandom_range(0, 2), q, lt, lat);
      check_op("rand5", 5, rn, rd, q, lt, lat, 2.0 ** -21);
    end
    for (int i = 0; i < 200; i++) begin
      rn = rnd_mant();
      rd = rnd_mant();
      run_op(3, rn, rd, $urandom_range(0, 2), q, lt, lat);
      check_op("rand3", 3, rn, rd, q, lt, lat, 2.0 ** -6);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
